vga_sincronia: RTL

- VGA 640x480@60 timing generator; the producer side of the pixel-coordinate interface.
- Divides the system clock into a pixel tick, then runs the horizontal counter (Columnas) and vertical counter (Filas).
- Emits registered hsync/vsync, a video-active flag and a frame-start pulse.
- Columnas/Filas feed the text-ROM addressing block and the colour path. Counter origin is the start of the sync pulse, so active video begins at column H_SYNC+H_BP (144) and row V_SYNC+V_BP (35).

---
 rtl/vga_sincronia.sv | 114 +++++++++++
 1 files changed

// File: rtl/vga_sincronia.sv
// VGA timing generator (640x480@60 by default).
// A clock divider produces the pixel tick; the column/row counters advance on
// that tick, and every timing flag is registered from the next-state counter
// values so flags and counters change on the same clock edge.
// Counter origin is the start of the sync pulse, so active video begins at
// column H_SYNC+H_BP and row V_SYNC+V_BP.
module vga_sincronia #(
    parameter int CLK_DIV  = 2,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACT    = 640,
    parameter int H_FP     = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACT    = 480,
    parameter int V_FP     = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] Columnas,
    output logic [9:0] Filas,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pix_tick,
    output logic       frame_start
);

    localparam int H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int DW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_SYNC_E = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_E = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_LO = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_ACT_HI = 10'(H_SYNC + H_BP + H_ACT - 1);
    localparam logic [9:0] V_ACT_LO = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_ACT_HI = 10'(V_SYNC + V_BP + V_ACT - 1);

    logic [DW-1:0] div_reg, div_next;
    logic [9:0]    col_reg, col_next;
    logic [9:0]    row_reg, row_next;
    logic          pix_tick_reg, pix_tick_next;
    logic          hsync_reg, vsync_reg, video_on_reg, frame_start_reg;
    logic          frame_wrap;

    // Next-state logic: divider wrap, pixel-tick flag and counter advance/wrap.
    always_comb begin
        div_next      = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
        pix_tick_next = (div_next == DIV_LAST);
        col_next      = col_reg;
        row_next      = row_reg;
        frame_wrap    = 1'b0;
        // pix_tick_reg marks the clock in which the divider sits at its last
        // count, so counters move on the edge that ends that pixel period.
        if (pix_tick_reg) begin
            if (col_reg == H_LAST) begin
                col_next = '0;
                if (row_reg == V_LAST) begin
                    row_next   = '0;
                    frame_wrap = 1'b1;
                end else begin
                    row_next = row_reg + 10'd1;
                end
            end else begin
                col_next = col_reg + 10'd1;
            end
        end
    end

    // Divider, counters and tick flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_reg      <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            pix_tick_reg <= 1'b0;
        end else begin
            div_reg      <= div_next;
            col_reg      <= col_next;
            row_reg      <= row_next;
            pix_tick_reg <= pix_tick_next;
        end
    end

    // Timing flags decoded from next-state counters for zero skew vs the counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg       <= SYNC_POL;
            vsync_reg       <= SYNC_POL;
            video_on_reg    <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            hsync_reg       <= (col_next < H_SYNC_E) ? SYNC_POL : ~SYNC_POL;
            vsync_reg       <= (row_next < V_SYNC_E) ? SYNC_POL : ~SYNC_POL;
            video_on_reg    <= (col_next >= H_ACT_LO) && (col_next <= H_ACT_HI) &&
                               (row_next >= V_ACT_LO) && (row_next <= V_ACT_HI);
            frame_start_reg <= frame_wrap;
        end
    end

    assign Columnas    = col_reg;
    assign Filas       = row_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign video_on    = video_on_reg;
    assign pix_tick    = pix_tick_reg;
    assign frame_start = frame_start_reg;

endmodule
